// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : Shared types and helpers for the DES result collector slice:
//            collector FSM encoding, default data widths, FIFO pointer width.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

  localparam int unsigned DES_CW_DEFAULT = 64;
  localparam int unsigned DES_DW_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_RELEASE = 2'd3
  } coll_state_e;

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : des_result_fifo
// Purpose  : Show-ahead synchronous FIFO. The head entry is presented on
//            rdata_o whenever the FIFO is not empty (zero otherwise). A
//            synchronous clear empties it and takes priority over push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module des_result_fifo
  import des_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [W-1:0]                wdata_i,
  input  logic                        pop_i,
  output logic [W-1:0]                rdata_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [ptr_width(DEPTH)-1:0] fill_level_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign full_o       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fill_level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the head slot in the same cycle, so push is legal at full
  // only when paired with a real pop; a lone push at full is dropped.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Head entry is gated to zero while empty so stale storage never shows.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state; clear overrides both push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/des_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : des_result_collector
// Purpose  : Captures {counter, ciphertext} test results from the DES block
//            wrapper into a show-ahead FIFO, handshakes the wrapper on to the
//            next test vector, stalls while the FIFO is full, and latches the
//            final counter when the search reports done.
// Revision : 1.0 - initial release
// ============================================================================
module des_result_collector
  import des_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = DES_CW_DEFAULT,
  parameter int unsigned DW    = DES_DW_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        test_res_ready,
  input  logic                        done,
  input  logic [CW-1:0]               counter,
  input  logic [DW-1:0]               ciphertext,
  output logic                        advance_test_cmd,
  input  logic                        rd_en,
  output logic                        rd_empty,
  output logic [CW-1:0]               rd_counter,
  output logic [DW-1:0]               rd_ciphertext,
  output logic [ptr_width(DEPTH)-1:0] fill_level,
  output logic [CW-1:0]               final_counter,
  output logic                        final_valid,
  output logic                        stall
);

  coll_state_e      state_q;
  coll_state_e      state_d;
  logic             advance_q;
  logic             advance_d;
  logic [CW-1:0]    final_counter_q;
  logic [CW-1:0]    final_counter_d;
  logic             final_valid_q;
  logic             final_valid_d;
  logic             w_full;
  logic             w_push;
  logic             w_stall;
  logic [CW+DW-1:0] w_head;

  // Result FIFO; a push coinciding with clear is dropped inside the FIFO.
  des_result_fifo #(
    .DEPTH (DEPTH),
    .W     (CW + DW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .push_i       (w_push),
    .wdata_i      ({counter, ciphertext}),
    .pop_i        (rd_en),
    .rdata_o      (w_head),
    .empty_o      (rd_empty),
    .full_o       (w_full),
    .fill_level_o (fill_level)
  );

  assign rd_counter       = w_head[CW+DW-1:DW];
  assign rd_ciphertext    = w_head[DW-1:0];
  assign advance_test_cmd = advance_q;
  assign stall            = w_stall;
  assign final_counter    = final_counter_q;
  assign final_valid      = final_valid_q;

  // Handshake FSM: capture once, raise advance, wait for the wrapper to drop
  // its ready, then spend one cycle with advance low before looking again.
  // Enable only gates the start of a sequence, never its completion.
  always_comb begin
    state_d = state_q;
    w_push  = 1'b0;
    w_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && test_res_ready) begin
          if (w_full) w_stall = 1'b1;
          else        state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_push  = 1'b1;
        state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (!test_res_ready) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    advance_d = (state_d == ST_ADVANCE);
  end

  // FSM state and registered advance output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      advance_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      advance_q <= advance_d;
    end
  end

  // Done latch: the first done cycle seen while not yet valid captures the
  // counter (this covers both a rising edge and a level already high);
  // later done cycles are ignored until clear, which has priority.
  always_comb begin
    final_counter_d = final_counter_q;
    final_valid_d   = final_valid_q;
    if (clear) begin
      final_valid_d = 1'b0;
    end else if (done && !final_valid_q) begin
      final_counter_d = counter;
      final_valid_d   = 1'b1;
    end
  end

  // Done latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_counter_q <= '0;
      final_valid_q   <= 1'b0;
    end else begin
      final_counter_q <= final_counter_d;
      final_valid_q   <= final_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_result_collector
// Purpose  : Self-checking bench for des_result_collector with a behavioural
//            wrapper model, an in-order result queue as reference, vector
//            tables for the done/clear latch and the FIFO edge cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_result_collector;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CW     = 64;
  localparam int unsigned DW     = 64;
  localparam int          BUDGET = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          test_res_ready = 1'b0;
  logic          done = 1'b0;
  logic          rd_en = 1'b0;
  logic [CW-1:0] counter = '0;
  logic [DW-1:0] ciphertext = '0;
  logic          advance_test_cmd;
  logic          rd_empty;
  logic          stall;
  logic          final_valid;
  logic [CW-1:0] rd_counter;
  logic [CW-1:0] final_counter;
  logic [DW-1:0] rd_ciphertext;
  logic [$clog2(DEPTH):0] fill_level;

  logic       f_clear = 1'b0;
  logic       f_push = 1'b0;
  logic       f_pop = 1'b0;
  logic [7:0] f_wdata = '0;
  logic [7:0] f_rdata;
  logic       f_empty;
  logic       f_full;
  logic [2:0] f_fill;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: every result the wrapper presents is captured exactly once,
  // in presentation order, so an in-order queue predicts every read.
  logic [CW+DW-1:0] mq[$];

  typedef struct {
    logic        done;
    logic        clr;
    logic [63:0] cnt;
    logic [63:0] exp_fc;
    logic        exp_fv;
    logic [3:0]  exp_fill;
  } dvec_t;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] wd;
    logic [2:0] exp_fill;
    logic [7:0] exp_head;
    logic       exp_empty;
    logic       exp_full;
  } fvec_t;

  dvec_t dtab[11];
  fvec_t ftab[15];

  des_result_collector #(.DEPTH(DEPTH), .CW(CW), .DW(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .clear            (clear),
    .test_res_ready   (test_res_ready),
    .done             (done),
    .counter          (counter),
    .ciphertext       (ciphertext),
    .advance_test_cmd (advance_test_cmd),
    .rd_en            (rd_en),
    .rd_empty         (rd_empty),
    .rd_counter       (rd_counter),
    .rd_ciphertext    (rd_ciphertext),
    .fill_level       (fill_level),
    .final_counter    (final_counter),
    .final_valid      (final_valid),
    .stall            (stall)
  );

  des_result_fifo #(.DEPTH(4), .W(8)) u_fifo_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (f_clear),
    .push_i       (f_push),
    .wdata_i      (f_wdata),
    .pop_i        (f_pop),
    .rdata_o      (f_rdata),
    .empty_o      (f_empty),
    .full_o       (f_full),
    .fill_level_o (f_fill)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Wrapper model: present a result, wait for advance, drop ready one cycle
  // later, wait for advance to fall, then return to IDLE-side timing.
  task automatic present(input logic [63:0] c, input logic [63:0] d, input bit drop_en);
    int n;
    counter        = c;
    ciphertext     = d;
    test_res_ready = 1'b1;
    mq.push_back({c, d});
    n = 0;
    while (advance_test_cmd !== 1'b1 && n < BUDGET) begin
      nxt();
      n++;
      if (drop_en && n == 1) enable = 1'b0;
    end
    chk1("advance_rise", advance_test_cmd, 1'b1);
    nxt();
    test_res_ready = 1'b0;
    n = 0;
    while (advance_test_cmd !== 1'b0 && n < BUDGET) begin
      nxt();
      n++;
    end
    chk1("advance_fall", advance_test_cmd, 1'b0);
    nxt();
  endtask

  task automatic pop_one();
    logic [127:0] e;
    e = '0;
    rd_en = 1'b1;
    @(negedge clk);
    if (mq.size() > 0) e = mq.pop_front();
    chk1("pop_not_empty", rd_empty, 1'b0);
    chkv("pop_head", {rd_counter, rd_ciphertext}, e);
    nxt();
    rd_en = 1'b0;
  endtask

  task automatic reader(input int total, input bit rnd);
    int got;
    int cyc;
    logic [127:0] e;
    got = 0;
    cyc = 0;
    while (got < total && cyc < 4000) begin
      rd_en = rnd ? ($urandom_range(0, 9) < 4) : (cyc % 2 == 0);
      @(negedge clk);
      if (rd_en && !rd_empty) begin
        e = '0;
        if (mq.size() > 0) e = mq.pop_front();
        chkv("read_order", {rd_counter, rd_ciphertext}, e);
        got++;
      end
      nxt();
      cyc++;
    end
    rd_en = 1'b0;
    chkv("reader_count", 128'(got), 128'(total));
  endtask

  initial begin
    int n;
    logic [127:0] e;

    dtab[0]  = '{1'b0, 1'b0, 64'h1,    64'h0,    1'b0, 4'd1};
    dtab[1]  = '{1'b1, 1'b0, 64'h1234, 64'h1234, 1'b1, 4'd1};
    dtab[2]  = '{1'b1, 1'b0, 64'h1234, 64'h1234, 1'b1, 4'd1};
    dtab[3]  = '{1'b1, 1'b0, 64'h1234, 64'h1234, 1'b1, 4'd1};
    dtab[4]  = '{1'b0, 1'b0, 64'h9999, 64'h1234, 1'b1, 4'd1};
    dtab[5]  = '{1'b1, 1'b0, 64'h9999, 64'h1234, 1'b1, 4'd1};
    dtab[6]  = '{1'b0, 1'b1, 64'h9999, 64'h1234, 1'b0, 4'd0};
    dtab[7]  = '{1'b1, 1'b0, 64'h5555, 64'h5555, 1'b1, 4'd0};
    dtab[8]  = '{1'b1, 1'b1, 64'h7777, 64'h5555, 1'b0, 4'd0};
    dtab[9]  = '{1'b1, 1'b0, 64'h7777, 64'h7777, 1'b1, 4'd0};
    dtab[10] = '{1'b0, 1'b1, 64'h0,    64'h7777, 1'b0, 4'd0};

    ftab[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 3'd1, 8'h10, 1'b0, 1'b0};
    ftab[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'd2, 8'h10, 1'b0, 1'b0};
    ftab[2]  = '{1'b1, 1'b0, 1'b0, 8'h12, 3'd3, 8'h10, 1'b0, 1'b0};
    ftab[3]  = '{1'b1, 1'b0, 1'b0, 8'h13, 3'd4, 8'h10, 1'b0, 1'b1};
    ftab[4]  = '{1'b1, 1'b0, 1'b0, 8'h19, 3'd4, 8'h10, 1'b0, 1'b1};
    ftab[5]  = '{1'b1, 1'b1, 1'b0, 8'h14, 3'd4, 8'h11, 1'b0, 1'b1};
    ftab[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h12, 1'b0, 1'b0};
    ftab[7]  = '{1'b1, 1'b1, 1'b0, 8'h15, 3'd3, 8'h13, 1'b0, 1'b0};
    ftab[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 8'h14, 1'b0, 1'b0};
    ftab[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h15, 1'b0, 1'b0};
    ftab[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
    ftab[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
    ftab[12] = '{1'b1, 1'b0, 1'b0, 8'h20, 3'd1, 8'h20, 1'b0, 1'b0};
    ftab[13] = '{1'b1, 1'b0, 1'b1, 8'h21, 3'd0, 8'h00, 1'b1, 1'b0};
    ftab[14] = '{1'b1, 1'b1, 1'b1, 8'h22, 3'd0, 8'h00, 1'b1, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_advance", advance_test_cmd, 1'b0);
    chk1("rst_empty", rd_empty, 1'b1);
    chkv("rst_fill", 128'(fill_level), 128'(0));
    chk1("rst_final_valid", final_valid, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chkv("rst_rd_counter", 128'(rd_counter), 128'(0));
    chkv("rst_rd_ciphertext", 128'(rd_ciphertext), 128'(0));
    chkv("rst_final_counter", 128'(final_counter), 128'(0));
    nxt();
    rst_n  = 1'b1;
    enable = 1'b1;
    nxt();

    // Single result, cycle-exact handshake timing.
    counter        = 64'h10;
    ciphertext     = 64'hDEADBEEF_01234567;
    test_res_ready = 1'b1;
    @(negedge clk);
    chk1("lat_t0_adv", advance_test_cmd, 1'b0);
    nxt(); @(negedge clk);
    chk1("lat_t1_adv", advance_test_cmd, 1'b0);
    chkv("lat_t1_fill", 128'(fill_level), 128'(0));
    nxt(); @(negedge clk);
    chk1("lat_t2_adv", advance_test_cmd, 1'b1);
    chkv("lat_t2_fill", 128'(fill_level), 128'(1));
    chkv("lat_t2_head", {rd_counter, rd_ciphertext}, {64'h10, 64'hDEADBEEF_01234567});
    nxt(); @(negedge clk);
    chk1("lat_t3_adv", advance_test_cmd, 1'b1);
    nxt();
    test_res_ready = 1'b0;
    @(negedge clk);
    chk1("lat_t4_adv", advance_test_cmd, 1'b1);
    nxt(); @(negedge clk);
    chk1("lat_t5_adv", advance_test_cmd, 1'b0);
    nxt(); @(negedge clk);
    chk1("lat_t6_adv", advance_test_cmd, 1'b0);
    chkv("lat_t6_fill", 128'(fill_level), 128'(1));
    nxt();

    // Done latch and clear, table driven; results checked after each edge.
    for (int i = 0; i < 11; i++) begin
      done    = dtab[i].done;
      clear   = dtab[i].clr;
      counter = dtab[i].cnt;
      nxt();
      chkv("done_final_counter", 128'(final_counter), 128'(dtab[i].exp_fc));
      chk1("done_final_valid", final_valid, dtab[i].exp_fv);
      chkv("done_fill", 128'(fill_level), 128'(dtab[i].exp_fill));
    end
    done  = 1'b0;
    clear = 1'b0;
    mq.delete();
    chk1("clear_empty", rd_empty, 1'b1);

    // Enable dropped mid-sequence still completes; enable low blocks capture.
    present(64'h20, 64'h2020, 1'b1);
    @(negedge clk);
    chkv("en_mid_fill", 128'(fill_level), 128'(1));
    nxt();
    counter        = 64'h21;
    test_res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("en_low_adv", advance_test_cmd, 1'b0);
      chk1("en_low_stall", stall, 1'b0);
      chkv("en_low_fill", 128'(fill_level), 128'(1));
      nxt();
    end
    test_res_ready = 1'b0;
    enable         = 1'b1;
    nxt();
    pop_one();

    // Underflow: pop while empty is ignored.
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt(); @(negedge clk);
      chk1("underflow_empty", rd_empty, 1'b1);
      chkv("underflow_fill", 128'(fill_level), 128'(0));
    end
    nxt();
    rd_en = 1'b0;

    // Backpressure: eight fill the FIFO, the ninth waits for one read.
    for (int i = 0; i < 8; i++) present(64'(i), 64'hB000 + 64'(i), 1'b0);
    @(negedge clk);
    chkv("bp_fill_full", 128'(fill_level), 128'(DEPTH));
    nxt();
    counter        = 64'h8;
    ciphertext     = 64'hB008;
    test_res_ready = 1'b1;
    mq.push_back({64'h8, 64'hB008});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("bp_stall", stall, 1'b1);
      chk1("bp_no_adv", advance_test_cmd, 1'b0);
      nxt();
    end
    pop_one();
    n = 0;
    while (advance_test_cmd !== 1'b1 && n < BUDGET) begin
      nxt();
      n++;
    end
    chk1("bp_ninth_adv", advance_test_cmd, 1'b1);
    @(negedge clk);
    chkv("bp_ninth_fill", 128'(fill_level), 128'(DEPTH));
    chk1("bp_ninth_stall", stall, 1'b0);
    nxt();
    test_res_ready = 1'b0;
    n = 0;
    while (advance_test_cmd !== 1'b0 && n < BUDGET) begin
      nxt();
      n++;
    end
    chk1("bp_adv_fall", advance_test_cmd, 1'b0);
    nxt();
    for (int i = 0; i < 8; i++) pop_one();
    @(negedge clk);
    chk1("bp_drained", rd_empty, 1'b1);
    nxt();

    // Wrap-around: 20 results with reads every other cycle.
    fork
      begin
        for (int i = 0; i < 20; i++) present(64'(i), 64'hA5A5_0000_0000_0000 | 64'(i), 1'b0);
      end
      reader(20, 1'b0);
    join
    @(negedge clk);
    chk1("wrap_empty", rd_empty, 1'b1);
    chkv("wrap_fill", 128'(fill_level), 128'(0));
    nxt();

    // Reset asserted while advance is high.
    counter        = 64'h77;
    ciphertext     = 64'h88;
    test_res_ready = 1'b1;
    n = 0;
    while (advance_test_cmd !== 1'b1 && n < BUDGET) begin
      nxt();
      n++;
    end
    chk1("rstmid_adv_high", advance_test_cmd, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("rstmid_adv_async", advance_test_cmd, 1'b0);
    chk1("rstmid_empty", rd_empty, 1'b1);
    test_res_ready = 1'b0;
    mq.delete();
    nxt(); nxt();
    rst_n = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    chk1("rstmid_post_adv", advance_test_cmd, 1'b0);
    chk1("rstmid_post_empty", rd_empty, 1'b1);
    chkv("rstmid_post_fill", 128'(fill_level), 128'(0));
    nxt();
    present(64'h55, 64'h66, 1'b0);
    pop_one();

    // Randomized traffic against the in-order reference queue.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) nxt();
          present({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
        end
      end
      reader(40, 1'b1);
    join
    @(negedge clk);
    chk1("rand_empty", rd_empty, 1'b1);
    chkv("rand_model_left", 128'(mq.size()), 128'(0));
    nxt();

    // FIFO edge cases on a small instance: push+pop at full, clear priority.
    for (int i = 0; i < 15; i++) begin
      f_push  = ftab[i].push;
      f_pop   = ftab[i].pop;
      f_clear = ftab[i].clr;
      f_wdata = ftab[i].wd;
      nxt();
      chkv("fifo_fill", 128'(f_fill), 128'(ftab[i].exp_fill));
      chkv("fifo_head", 128'(f_rdata), 128'(ftab[i].exp_head));
      chk1("fifo_empty", f_empty, ftab[i].exp_empty);
      chk1("fifo_full", f_full, ftab[i].exp_full);
    end
    f_push  = 1'b0;
    f_pop   = 1'b0;
    f_clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
